uart_word_packetizer: RTL and testbench
=======================================

# uart_word_packetizer

Buffers 32-bit random words from the TRNG word source and sends them as framed, checksummed packets through the byte-level UART transmitter. It sits between the word producer (valid/ready) and the UART serializer (one-cycle data-valid pulse, active/done status), so the host can resynchronise and check integrity. It replaces ad-hoc byte sequencing with a fixed frame and a small elastic buffer.

## Interface
Parameters:
- WORDS_PER_PKT, 4: maximum payload words per packet, 1..255.
- FIFO_DEPTH, 8: word FIFO depth, power of two, at least 2.
- SYNC_BYTE, 8'hA5: first byte of every packet.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- word_i  in  32  word from the TRNG source.
- word_valid_i  in  1  word_i is valid.
- word_ready_o  out  1  FIFO can accept a word: `!rst && level != FIFO_DEPTH`. A push happens on any cycle where valid and ready are both high.
- flush_i  in  1  one-cycle request to send a partial packet.
- tx_byte_o  out  8  byte to the serializer; held stable until the next issue.
- tx_dv_o  out  1  one-cycle issue pulse to the serializer.
- tx_active_i  in  1  serializer busy.
- tx_done_i  in  1  serializer one-cycle completion pulse.
- pkt_done_o  out  1  one-cycle pulse when the checksum byte's tx_done_i arrives.
- busy_o  out  1  a packet is in progress (state != IDLE).
- seq_o  out  8  sequence number of the next packet.
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Frame layout: SYNC_BYTE, SEQ, LEN, then LEN words sent LSB-first, then CHK.
  - CHK is the XOR of SEQ, LEN and every payload byte. SYNC_BYTE is excluded.
  - Frame length is 4+4·LEN bytes.
- Packet start, from IDLE only:
  - Starts when level ≥ WORDS_PER_PKT, or when the flush latch is set and level ≥ 1.
  - LEN = min(level, WORDS_PER_PKT), captured at start.
- Flush latch:
  - Set by flush_i.
  - Cleared at packet start.
  - flush_i while level == 0 is ignored and does not set the latch.
- State machine: IDLE → HDR (3 bytes, index 0..2) → PAY (LEN·4 bytes) → CHK → IDLE.
- Byte issue (every state except IDLE):
  - Issue when pending == 0 and tx_active_i == 0.
  - Issue drives tx_byte_o, pulses tx_dv_o and sets pending.
  - pending clears on tx_done_i; the state or byte index advances on that same cycle.
  - Never issue a second byte before tx_done_i for the previous byte has been seen.
- Word pop: the FIFO is popped in the cycle byte 0 of each payload word issues. The word is copied into a 32-bit shift register, and bytes 1..3 come from that register.
- Sequence number:
  - seq_o increments on pkt_done_o and wraps from 255 to 0.
  - CHK accumulates as each byte issues.
- Simultaneous push and pop: both take effect and level is unchanged. Ready uses the current level, so a full FIFO refuses a push even when a pop happens in the same cycle.
- tx_done_i while pending == 0 is ignored.

## Timing
- Reset values:
  - tx_dv_o=0, tx_byte_o=0, pkt_done_o=0, busy_o=0, seq_o=0, level_o=0, word_ready_o=0 while rst is high.
  - State IDLE, FIFO empty, flush latch clear.
- Reset mid-packet aborts the packet:
  - Nothing further is issued and seq_o returns to 0.
  - A byte already in the serializer finishes on the line, because the serializer is not reset by this block.
- Start latency: the start condition is met at edge N; busy_o rises at N+1; the SYNC tx_dv_o pulse is at N+2, provided tx_active_i is low.
- Byte-to-byte gap: tx_dv_o for the next byte is pulsed the cycle after tx_done_i, if tx_active_i is low.
- pkt_done_o is registered and asserts the cycle after the CHK tx_done_i. busy_o falls in that same cycle.
- A push is visible in level_o the cycle after the handshake.

## Structure
- Shared package or header `uart_pkt_defs` holds:
  - the default SYNC_BYTE;
  - state encodings IDLE/HDR/PAY/CHK;
  - the header byte count, 3.
- One sub-module, `sync_word_fifo`: synchronous FIFO with parameters WIDTH and DEPTH, synchronous active-high reset, and push, pop, dout, level, full and empty. It uses first-word-fall-through, so dout is valid while !empty.
- Top level contains the FSM, byte mux, checksum, sequence counter and flush latch.

## Test plan
- WORDS_PER_PKT=2 with a serializer model (tx_active high for 10 cycles, then tx_done): push 0x11223344 and 0x55667788 → bytes A5 00 02 44 33 22 11 88 77 66 55 8A, one pkt_done_o pulse, seq_o=1.
- Next, push 0xDEADBEEF, then flush_i → bytes A5 01 01 EF BE AD DE 22. flush_i at level 0 → no bytes.
- Hold word_valid_i high with the serializer stalled → level_o reaches FIFO_DEPTH, word_ready_o drops, and no word is lost or duplicated against a reference queue.
- Run 256 packets → seq_o wraps 255→0; every CHK matches the model.
- Assert rst during the PAY state → outputs return to reset values within one cycle, and a clean packet with SEQ=00 follows re-fill.
- Emit a spurious tx_done_i while idle, then hold tx_active_i high after tx_done_i → no tx_dv_o pulse until tx_active_i is low.

Source files
------------

// File: rtl/uart_word_packetizer_pkg.sv
// Shared definitions for the UART word packetizer: frame constants and FSM state encoding.
package uart_pkt_defs;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int         HDR_BYTES     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    CHK  = 2'd3
  } pkt_state_e;

endpackage

// File: rtl/uart_word_packetizer_fifo.sv
// Synchronous first-word-fall-through FIFO; dout is the oldest entry whenever !empty.
module sync_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = count_q;

  // Storage carries no reset; only pointers and occupancy are control state.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_packetizer.sv
// Frames buffered 32-bit words as SYNC/SEQ/LEN/payload/CHK packets and feeds them
// byte by byte to a UART serializer using an issue/done handshake.
module uart_word_packetizer
  import uart_pkt_defs::*;
#(
  parameter int         WORDS_PER_PKT = 4,
  parameter int         FIFO_DEPTH    = 8,
  parameter logic [7:0] SYNC_BYTE     = DEF_SYNC_BYTE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   word_i,
  input  logic                          word_valid_i,
  output logic                          word_ready_o,
  input  logic                          flush_i,
  output logic [7:0]                    tx_byte_o,
  output logic                          tx_dv_o,
  input  logic                          tx_active_i,
  input  logic                          tx_done_i,
  output logic                          pkt_done_o,
  output logic                          busy_o,
  output logic [7:0]                    seq_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [7:0] clamp_len(input logic [31:0] lvl);
    if (lvl >= 32'(WORDS_PER_PKT)) return 8'(WORDS_PER_PKT);
    return 8'(lvl);
  endfunction

  logic [LW-1:0] level;
  logic [31:0]   level32;
  logic [31:0]   fifo_dout;
  logic          fifo_full, fifo_empty;
  logic          push, pop;

  pkt_state_e    state_q;
  logic [1:0]    idx_q;
  logic [7:0]    word_cnt_q, len_q, seq_q, chk_q, tx_byte_q;
  logic [31:0]   shift_q;
  logic          pending_q, flush_q, tx_dv_q, pkt_done_q;

  logic          start, issue, advance;
  logic [7:0]    issue_byte;

  assign word_ready_o = !rst && !fifo_full;
  assign push         = word_valid_i && word_ready_o;
  assign level32      = 32'(level);

  assign start   = (state_q == IDLE) &&
                   ((level32 >= 32'(WORDS_PER_PKT)) || (flush_q && level32 != 32'd0));
  assign issue   = (state_q != IDLE) && !pending_q && !tx_active_i;
  assign advance = (state_q != IDLE) && pending_q && tx_done_i;
  assign pop     = issue && (state_q == PAY) && (idx_q == 2'd0) && !fifo_empty;

  sync_word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (word_i),
    .dout_o  (fifo_dout),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    issue_byte = chk_q;
    case (state_q)
      HDR: begin
        case (idx_q)
          2'd0:    issue_byte = SYNC_BYTE;
          2'd1:    issue_byte = seq_q;
          default: issue_byte = len_q;
        endcase
      end
      PAY:     issue_byte = (idx_q == 2'd0) ? fifo_dout[7:0] : shift_q[7:0];
      default: issue_byte = chk_q;
    endcase
  end

  // Payload shift register and running checksum (SYNC excluded).
  always_ff @(posedge clk) begin
    if (start) begin
      chk_q <= '0;
    end else if (issue && (state_q == PAY || (state_q == HDR && idx_q != 2'd0))) begin
      chk_q <= chk_q ^ issue_byte;
    end
    if (pop) begin
      shift_q <= fifo_dout >> 8;
    end else if (issue && state_q == PAY) begin
      shift_q <= shift_q >> 8;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      seq_q      <= '0;
      pending_q  <= 1'b0;
      flush_q    <= 1'b0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      tx_dv_q    <= issue;
      pkt_done_q <= 1'b0;
      if (issue) begin
        tx_byte_q <= issue_byte;
        pending_q <= 1'b1;
      end else if (advance) begin
        pending_q <= 1'b0;
      end

      if (start) flush_q <= 1'b0;
      else if (flush_i && level32 != 32'd0) flush_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= HDR;
            idx_q   <= '0;
            len_q   <= clamp_len(level32);
          end
        end
        HDR: begin
          if (advance) begin
            if (idx_q == 2'(HDR_BYTES - 1)) begin
              state_q    <= PAY;
              idx_q      <= '0;
              word_cnt_q <= '0;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        PAY: begin
          if (advance) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if (word_cnt_q == len_q - 8'd1) state_q <= CHK;
              else word_cnt_q <= word_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          if (advance) begin
            state_q    <= IDLE;
            pkt_done_q <= 1'b1;
            seq_q      <= seq_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign tx_byte_o  = tx_byte_q;
  assign tx_dv_o    = tx_dv_q;
  assign pkt_done_o = pkt_done_q;
  assign busy_o     = (state_q != IDLE);
  assign seq_o      = seq_q;
  assign level_o    = level;

endmodule

// File: tb/tb_uart_word_packetizer.sv
// Scoreboard bench: a word-level packet model fills expected byte/sequence queues,
// and a serializer model pops and compares every issued byte and pkt_done pulse.
module tb_uart_word_packetizer;

  localparam int WPP   = 2;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] word_i = '0;
  logic        word_valid_i = 1'b0;
  logic        word_ready_o;
  logic        flush_i = 1'b0;
  logic [7:0]  tx_byte_o;
  logic        tx_dv_o;
  logic        tx_active_i = 1'b0;
  logic        tx_done_i = 1'b0;
  logic        pkt_done_o;
  logic        busy_o;
  logic [7:0]  seq_o;
  logic [3:0]  level_o;

  uart_word_packetizer #(
    .WORDS_PER_PKT (WPP),
    .FIFO_DEPTH    (DEPTH),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .flush_i      (flush_i),
    .tx_byte_o    (tx_byte_o),
    .tx_dv_o      (tx_dv_o),
    .tx_active_i  (tx_active_i),
    .tx_done_i    (tx_done_i),
    .pkt_done_o   (pkt_done_o),
    .busy_o       (busy_o),
    .seq_o        (seq_o),
    .level_o      (level_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  exp_bytes [$];
  logic [7:0]  exp_seq   [$];
  logic [31:0] pend      [$];
  logic [7:0]  rx_log    [$];
  int          seq_m = 0;
  int          pkts_model = 0;
  int          pkts_seen = 0;
  int          bytes_seen = 0;
  bit          wrap_seen = 0;

  int ser_len   = 10;
  int ser_hold  = 0;
  bit ser_stall = 0;
  int ser_cnt   = 0;
  int hold_cnt  = 0;
  int spur_req  = 0;
  int spur_ack  = 0;

  byte unsigned exp_p1 [12] = '{8'hA5, 8'h00, 8'h02, 8'h44, 8'h33, 8'h22,
                               8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'h8A};
  byte unsigned exp_p2 [8]  = '{8'hA5, 8'h01, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_checks++;
    $display("FAIL %s: timeout or unexpected event", nm);
  endtask

  // Reference: a packet is a group of LEN words in arrival order, framed and XORed.
  function automatic void emit(input int len);
    logic [7:0]  c, b;
    logic [31:0] w;
    c = 8'(seq_m) ^ 8'(len);
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'(seq_m));
    exp_bytes.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      w = pend.pop_front();
      for (int k = 0; k < 4; k++) begin
        b = 8'((w / (32'd1 << (8 * k))) % 256);
        exp_bytes.push_back(b);
        c = c ^ b;
      end
    end
    exp_bytes.push_back(c);
    seq_m = (seq_m + 1) % 256;
    exp_seq.push_back(8'(seq_m));
    pkts_model++;
  endfunction

  function automatic void model_accept(input logic [31:0] w);
    pend.push_back(w);
    if (pend.size() >= WPP) emit(WPP);
  endfunction

  task automatic push_word(input logic [31:0] w, input int maxc, output bit ok);
    int c;
    ok = 0;
    c = 0;
    word_i = w;
    word_valid_i = 1'b1;
    while (!ok && c < maxc) begin
      if (word_ready_o) begin
        ok = 1;
        model_accept(w);
      end
      @(negedge clk);
      c++;
    end
    word_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    int c;
    c = 0;
    while (!(exp_bytes.size() == 0 && exp_seq.size() == 0 && !busy_o &&
             ser_cnt == 0 && hold_cnt == 0) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (c >= maxc) fail(nm);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_dv"},       tx_dv_o, 0);
    check({tag, "_tx_byte"},     tx_byte_o, 0);
    check({tag, "_pkt_done"},    pkt_done_o, 0);
    check({tag, "_busy"},        busy_o, 0);
    check({tag, "_seq"},         seq_o, 0);
    check({tag, "_level"},       level_o, 0);
    check({tag, "_word_ready"},  word_ready_o, 0);
  endtask

  // Serializer model and output monitor.
  initial begin
    forever begin
      @(negedge clk);
      tx_done_i = 1'b0;
      if (tx_dv_o) begin
        check("issue_while_line_idle", tx_active_i, 0);
        if (exp_bytes.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_byte_o);
        end else begin
          check("tx_byte", tx_byte_o, exp_bytes.pop_front());
        end
        rx_log.push_back(tx_byte_o);
        bytes_seen++;
        ser_cnt = ser_len;
        tx_active_i = 1'b1;
      end else if (ser_cnt > 0) begin
        if (!ser_stall) begin
          ser_cnt--;
          if (ser_cnt == 0) begin
            tx_done_i = 1'b1;
            hold_cnt = ser_hold;
            tx_active_i = (ser_hold > 0);
          end
        end
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) tx_active_i = 1'b0;
      end else if (spur_req != spur_ack) begin
        tx_done_i = 1'b1;
        spur_ack = spur_req;
      end
      if (pkt_done_o) begin
        check("busy_falls_with_pkt_done", busy_o, 0);
        if (exp_seq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pkt_done: got seq %0h expected none", seq_o);
        end else begin
          check("seq_after_pkt", seq_o, exp_seq.pop_front());
        end
        pkts_seen++;
        if (seq_o == 8'd0) wrap_seen = 1;
      end
    end
  end

  initial begin
    #(1500000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base, c, n;

    // Reset values
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed full packet
    base = rx_log.size();
    push_word(32'h11223344, 50, ok);
    push_word(32'h55667788, 50, ok);
    wait_idle("pkt1_idle", 1000);
    check("pkt1_len", rx_log.size() - base, 12);
    for (int i = 0; i < 12 && base + i < rx_log.size(); i++)
      check($sformatf("pkt1_byte%0d", i), rx_log[base + i], exp_p1[i]);
    check("pkt1_seq", seq_o, 1);

    // Partial packet via flush
    base = rx_log.size();
    push_word(32'hDEADBEEF, 50, ok);
    idle_cycles(30);
    check("partial_waits_busy", busy_o, 0);
    check("partial_level", level_o, 1);
    pulse_flush();
    emit(pend.size());
    wait_idle("pkt2_idle", 1000);
    check("pkt2_len", rx_log.size() - base, 8);
    for (int i = 0; i < 8 && base + i < rx_log.size(); i++)
      check($sformatf("pkt2_byte%0d", i), rx_log[base + i], exp_p2[i]);

    // Flush at level 0 must be ignored and must not arm a later partial
    base = rx_log.size();
    pulse_flush();
    idle_cycles(30);
    check("flush_empty_no_bytes", rx_log.size() - base, 0);
    push_word(32'hCAFEF00D, 50, ok);
    idle_cycles(30);
    check("flush_empty_not_latched", busy_o, 0);
    push_word(32'h0BADC0DE, 50, ok);
    wait_idle("pkt3_idle", 1000);

    // Stalled serializer: FIFO fills, refuses, then drains without loss
    ser_stall = 1;
    for (int i = 0; i < DEPTH; i++) push_word($urandom, 20, ok);
    idle_cycles(3);
    check("stall_level_full", level_o, DEPTH);
    check("stall_ready_low", word_ready_o, 0);
    push_word(32'h99999999, 20, ok);
    check("stall_push_refused", ok, 0);
    ser_stall = 0;
    push_word(32'h99999999, 2000, ok);
    check("stall_push_after_drain", ok, 1);
    push_word(32'hAAAAAAAA, 2000, ok);
    wait_idle("stall_idle", 5000);

    // Randomized traffic until the sequence number wraps
    n = 0;
    while (pkts_model < 262 && n < 2000) begin
      ser_len = $urandom_range(1, 6);
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        idle_cycles($urandom_range(0, 3));
        push_word($urandom, 3000, ok);
        if (!ok) fail("rand_push");
      end
      if ($urandom_range(0, 3) == 0) begin
        wait_idle("rand_idle", 5000);
        if (pend.size() > 0) begin
          pulse_flush();
          emit(pend.size());
          wait_idle("rand_flush_idle", 5000);
        end
      end
      n++;
    end
    wait_idle("rand_final_idle", 10000);
    if (pend.size() > 0) begin
      pulse_flush();
      emit(pend.size());
      wait_idle("rand_final_flush", 5000);
    end
    check("seq_wrapped", wrap_seen, 1);
    check("pkts_seen", pkts_seen, pkts_model);

    // Reset while in the payload
    ser_len = 10;
    base = bytes_seen;
    push_word($urandom, 50, ok);
    push_word($urandom, 50, ok);
    c = 0;
    while (bytes_seen < base + 5 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 2000) fail("reach_payload");
    idle_cycles(3);
    rst = 1'b1;
    exp_bytes.delete();
    exp_seq.delete();
    pend.delete();
    seq_m = 0;
    @(negedge clk);
    check_reset_outputs("midpkt_reset");
    @(negedge clk);
    rst = 1'b0;
    c = 0;
    while ((ser_cnt != 0 || hold_cnt != 0) && c < 100) begin
      @(negedge clk);
      c++;
    end
    idle_cycles(5);
    check("after_reset_idle", busy_o, 0);
    base = rx_log.size();
    push_word($urandom, 50, ok);
    push_word($urandom, 50, ok);
    wait_idle("post_reset_idle", 1000);
    check("post_reset_len", rx_log.size() - base, 12);
    if (rx_log.size() >= base + 3) begin
      check("post_reset_sync", rx_log[base], 8'hA5);
      check("post_reset_seq0", rx_log[base + 1], 8'h00);
    end

    // Spurious done while idle, then line held busy after each done
    base = rx_log.size();
    spur_req++;
    idle_cycles(20);
    check("spurious_done_busy", busy_o, 0);
    check("spurious_done_no_bytes", rx_log.size() - base, 0);
    ser_hold = 15;
    ser_len = 4;
    push_word($urandom, 50, ok);
    push_word($urandom, 50, ok);
    wait_idle("hold_idle", 3000);
    check("hold_len", rx_log.size() - base, 12);
    ser_hold = 0;

    check("scoreboard_empty", exp_bytes.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
